// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - packs FIFO read words into wide beats, closing partial beats on flush or idle timeout
`ifndef DSIZE
`define DSIZE 8
`endif

module fifo_rd_packer #(
  parameter int DSIZE   = `DSIZE,
  parameter int PACK    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [DSIZE-1:0]      rdata,
  input  logic                  rempty,
  output logic                  rinc,
  input  logic                  flush,
  output logic [DSIZE*PACK-1:0] out_data,
  output logic [PACK-1:0]       out_keep,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CW = $clog2(PACK + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(PACK);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idle;
  logic [DSIZE*PACK-1:0] r_lanes;
  logic [PACK-1:0]       r_keep;
  logic                  w_pop;
  logic                  w_last_word;
  logic                  w_timeout;
  logic                  w_accept;

  // No popping while a beat is presented, so OUT holds its lanes untouched.
  assign w_pop       = rrst_n & ~rempty & (r_state != S_OUT);
  assign w_last_word = w_pop && ((r_cnt + CW'(1)) == CNT_FULL);
  assign w_timeout   = !w_pop && (r_idle == IDLE_LAST);
  assign w_accept    = (r_state == S_OUT) && out_ready;
  assign rinc        = w_pop;

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_pop) w_next = S_FILL;
      S_FILL: if (w_last_word || flush || w_timeout) w_next = S_OUT;
      S_OUT:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (r_state == S_OUT);
    out_data  = r_lanes;
    out_keep  = r_keep;
  end

  // Lanes are zeroed on accept, so any lane never written reads back as zero.
  always_ff @(posedge rclk) begin
    if (!rrst_n || w_accept) begin
      r_cnt   <= '0;
      r_idle  <= '0;
      r_lanes <= '0;
      r_keep  <= '0;
    end else if (w_pop) begin
      for (int i = 0; i < PACK; i++) begin
        if (r_cnt == CW'(i)) begin
          r_lanes[i*DSIZE +: DSIZE] <= rdata;
          r_keep[i]                 <= 1'b1;
        end
      end
      r_cnt  <= r_cnt + CW'(1);
      r_idle <= '0;
    end else if (r_state == S_FILL) begin
      r_idle <= r_idle + IW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - directed and randomized checks of fifo_rd_packer against a queue model of the FIFO and beats
module tb_fifo_rd_packer;

  localparam int DSIZE   = 8;
  localparam int PACK    = 4;
  localparam int TIMEOUT = 16;

  logic                  rclk = 1'b0;
  logic                  rrst_n;
  logic [DSIZE-1:0]      rdata;
  logic                  rempty;
  logic                  rinc;
  logic                  flush;
  logic [DSIZE*PACK-1:0] out_data;
  logic [PACK-1:0]       out_keep;
  logic                  out_valid;
  logic                  out_ready;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [7:0]  fq[$];
  logic        stall;
  logic        s_rinc, s_valid, s_ready;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic [31:0] b_data[$];
  logic [3:0]  b_keep[$];
  int          b_cyc[$];
  int          pop_cyc[$];
  logic [7:0]  popped[$];

  fifo_rd_packer #(.DSIZE(DSIZE), .PACK(PACK), .TIMEOUT(TIMEOUT)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rdata     (rdata),
    .rempty    (rempty),
    .rinc      (rinc),
    .flush     (flush),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 rclk = ~rclk;

  task automatic refresh();
    rempty = stall || (fq.size() == 0);
    rdata  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  // Sample at negedge, then apply the FIFO pop just after the posedge.
  task automatic tick();
    @(negedge rclk);
    s_rinc  = rinc;
    s_valid = out_valid;
    s_ready = out_ready;
    s_data  = out_data;
    s_keep  = out_keep;
    if (rrst_n && out_valid && out_ready) begin
      b_data.push_back(out_data);
      b_keep.push_back(out_keep);
      b_cyc.push_back(cyc);
    end
    @(posedge rclk);
    #1;
    if (s_rinc && fq.size() != 0) begin
      popped.push_back(fq[0]);
      pop_cyc.push_back(cyc);
      void'(fq.pop_front());
    end
    cyc++;
    refresh();
  endtask

  task automatic clear_logs();
    b_data.delete();
    b_keep.delete();
    b_cyc.delete();
    pop_cyc.delete();
    popped.delete();
  endtask

  task automatic test_reset();
    stall = 1'b0;
    fq.delete();
    fq.push_back(8'h5A);
    fq.push_back(8'hC3);
    rrst_n = 1'b0;
    refresh();
    tick();
    tests_run++;
    if (s_rinc !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rinc_first: got %b want 0", s_rinc);
    end
    tick();
    tests_run++;
    if (s_valid !== 1'b0 || s_keep !== 4'h0 || s_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid=%b keep=%h data=%h want 0/0/0", s_valid, s_keep, s_data);
    end
    tests_run++;
    if (s_rinc !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rinc_held: got %b want 0", s_rinc);
    end
    fq.delete();
    stall = 1'b1;
    rrst_n = 1'b1;
    refresh();
    tick();
    tests_run++;
    if (s_valid !== 1'b0 || s_rinc !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_idle: valid=%b rinc=%b want 0/0", s_valid, s_rinc);
    end
    clear_logs();
  endtask

  task automatic test_full_beat();
    logic [3:0]  rh;
    int          rcount, vcount, vfirst;
    logic [31:0] vd;
    logic [3:0]  vk;
    clear_logs();
    out_ready = 1'b1;
    fq.push_back(8'h11);
    fq.push_back(8'h22);
    fq.push_back(8'h33);
    fq.push_back(8'h44);
    stall = 1'b0;
    refresh();
    rh = '0; rcount = 0; vcount = 0; vfirst = -1; vd = '0; vk = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i < 4) rh[i] = s_rinc;
      if (s_rinc) rcount++;
      if (s_valid) begin
        vcount++;
        if (vfirst < 0) begin
          vfirst = i; vd = s_data; vk = s_keep;
        end
      end
    end
    tests_run++;
    if (rh !== 4'hF || rcount != 4) begin
      tests_failed++;
      $display("FAIL full_rinc: first4=%b total=%0d want 1111/4", rh, rcount);
    end
    tests_run++;
    if (vcount != 1 || vfirst != 4) begin
      tests_failed++;
      $display("FAIL full_valid_timing: count=%0d first=%0d want 1/4", vcount, vfirst);
    end
    tests_run++;
    if (vd !== 32'h44332211 || vk !== 4'hF) begin
      tests_failed++;
      $display("FAIL full_beat: data=%h keep=%h want 44332211/f", vd, vk);
    end
  endtask

  task automatic test_timeout();
    int          last_pop, vfirst, vcount;
    logic [31:0] vd;
    logic [3:0]  vk;
    clear_logs();
    out_ready = 1'b1;
    fq.push_back(8'hA1);
    fq.push_back(8'hB2);
    stall = 1'b0;
    refresh();
    last_pop = -1; vfirst = -1; vcount = 0; vd = '0; vk = '0;
    for (int i = 0; i < TIMEOUT + 12; i++) begin
      tick();
      if (s_rinc) last_pop = i;
      if (s_valid) begin
        vcount++;
        if (vfirst < 0) begin
          vfirst = i; vd = s_data; vk = s_keep;
        end
      end
    end
    // out_valid rises on the TIMEOUT-th edge after the edge that consumed the last word.
    tests_run++;
    if (last_pop != 1 || vfirst != last_pop + TIMEOUT + 1 || vcount != 1) begin
      tests_failed++;
      $display("FAIL timeout_timing: last_pop=%0d first_valid=%0d count=%0d want 1/%0d/1",
               last_pop, vfirst, vcount, 2 + TIMEOUT);
    end
    tests_run++;
    if (vd !== 32'h0000B2A1 || vk !== 4'h3) begin
      tests_failed++;
      $display("FAIL timeout_beat: data=%h keep=%h want 0000b2a1/3", vd, vk);
    end
  endtask

  task automatic test_flush_pop();
    logic [7:0]  x, y, z;
    logic [31:0] exp_d;
    logic        pop_at_flush;
    clear_logs();
    out_ready = 1'b1;
    x = 8'($urandom); y = 8'($urandom); z = 8'($urandom);
    exp_d = {8'h00, z, y, x};
    fq.push_back(x);
    fq.push_back(y);
    fq.push_back(z);
    stall = 1'b0;
    refresh();
    tick();
    tick();
    flush = 1'b1;
    tick();
    pop_at_flush = s_rinc;
    flush = 1'b0;
    tick();
    tests_run++;
    if (pop_at_flush !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_pop_rinc: got %b want 1", pop_at_flush);
    end
    tests_run++;
    if (s_valid !== 1'b1 || s_keep !== 4'h7 || s_data !== exp_d) begin
      tests_failed++;
      $display("FAIL flush_pop_beat: valid=%b keep=%h data=%h want 1/7/%h", s_valid, s_keep, s_data, exp_d);
    end
    for (int i = 0; i < TIMEOUT + 4; i++) tick();
    tests_run++;
    if (b_data.size() != 1) begin
      tests_failed++;
      $display("FAIL flush_pop_count: got %0d beats want 1", b_data.size());
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  w[8];
    logic [31:0] exp1, exp2;
    bit          got2;
    clear_logs();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w[i] = 8'($urandom);
      fq.push_back(w[i]);
    end
    exp1 = {w[3], w[2], w[1], w[0]};
    exp2 = {w[7], w[6], w[5], w[4]};
    stall = 1'b0;
    refresh();
    repeat (4) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (s_rinc !== 1'b0 || s_valid !== 1'b1 || s_data !== exp1 || s_keep !== 4'hF) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: rinc=%b valid=%b data=%h keep=%h want 0/1/%h/f",
                 i, s_rinc, s_valid, s_data, s_keep, exp1);
      end
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (s_valid !== 1'b1 || s_rinc !== 1'b0 || b_data.size() != 1) begin
      tests_failed++;
      $display("FAIL bp_accept: valid=%b rinc=%b beats=%0d want 1/0/1", s_valid, s_rinc, b_data.size());
    end
    tick();
    tests_run++;
    if (s_valid !== 1'b0 || s_rinc !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_after_accept: valid=%b rinc=%b want 0/1", s_valid, s_rinc);
    end
    got2 = 1'b0;
    for (int i = 0; i < 12 && !got2; i++) begin
      tick();
      if (b_data.size() >= 2) got2 = 1'b1;
    end
    tests_run++;
    if (!got2 || b_data[1] !== exp2 || b_keep[1] !== 4'hF) begin
      tests_failed++;
      $display("FAIL bp_second_beat: beats=%0d data=%h want %h/f", b_data.size(),
               (b_data.size() >= 2) ? b_data[1] : 32'h0, exp2);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [7:0]  n[4];
    logic [31:0] exp_d;
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) fq.push_back(8'($urandom));
    stall = 1'b0;
    refresh();
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      n[i] = 8'($urandom);
      fq.push_back(n[i]);
    end
    exp_d = {n[3], n[2], n[1], n[0]};
    rrst_n = 1'b0;
    refresh();
    tick();
    tests_run++;
    if (s_rinc !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_rinc: got %b want 0", s_rinc);
    end
    rrst_n = 1'b1;
    for (int i = 0; i < TIMEOUT + 12; i++) tick();
    tests_run++;
    if (b_data.size() != 1) begin
      tests_failed++;
      $display("FAIL midreset_beat_count: got %0d want 1", b_data.size());
    end else if (b_data[0] !== exp_d || b_keep[0] !== 4'hF) begin
      tests_failed++;
      $display("FAIL midreset_beat: data=%h keep=%h want %h/f", b_data[0], b_keep[0], exp_d);
    end
  endtask

  task automatic test_flush_idle();
    clear_logs();
    fq.delete();
    stall = 1'b1;
    out_ready = 1'b1;
    flush = 1'b1;
    refresh();
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (s_rinc !== 1'b0 || s_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL flush_idle[%0d]: rinc=%b valid=%b want 0/0", i, s_rinc, s_valid);
      end
    end
    flush = 1'b0;
    for (int i = 0; i < TIMEOUT + 4; i++) tick();
    tests_run++;
    if (b_data.size() != 0) begin
      tests_failed++;
      $display("FAIL flush_idle_beats: got %0d want 0", b_data.size());
    end
  endtask

  task automatic test_random();
    logic [7:0]  sent[$];
    logic [7:0]  recv[$];
    logic [7:0]  w;
    logic        pv, pr;
    logic [31:0] pd;
    logic [3:0]  pk, ek;
    int          nb, zero_bad, mism, rinc_bad, hold_bad;
    clear_logs();
    fq.delete();
    stall = 1'b0;
    flush = 1'b0;
    pv = 1'b0; pr = 1'b0; pd = '0; pk = '0;
    rinc_bad = 0; hold_bad = 0;
    for (int c = 0; c < 1500; c++) begin
      if (fq.size() < 6 && $urandom_range(0, 3) != 0) begin
        w = 8'($urandom);
        fq.push_back(w);
        sent.push_back(w);
      end
      if ($urandom_range(0, 9) == 0) stall = ~stall;
      out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 19) == 0);
      refresh();
      tick();
      if (s_rinc && s_valid) rinc_bad++;
      if (pv && !pr && (!s_valid || s_data !== pd || s_keep !== pk)) hold_bad++;
      pv = s_valid; pr = s_ready; pd = s_data; pk = s_keep;
    end
    flush = 1'b0;
    stall = 1'b0;
    out_ready = 1'b1;
    refresh();
    for (int c = 0; c < 3 * TIMEOUT + 20; c++) tick();
    tests_run++;
    if (rinc_bad != 0) begin
      tests_failed++;
      $display("FAIL rand_rinc_in_out: %0d cycles popped while presenting, want 0", rinc_bad);
    end
    tests_run++;
    if (hold_bad != 0) begin
      tests_failed++;
      $display("FAIL rand_hold: %0d unstable backpressure cycles, want 0", hold_bad);
    end
    zero_bad = 0;
    for (int b = 0; b < b_data.size(); b++) begin
      nb = $countones(b_keep[b]);
      ek = 4'((1 << nb) - 1);
      tests_run++;
      if (nb == 0 || b_keep[b] !== ek) begin
        tests_failed++;
        $display("FAIL rand_keep_shape[%0d]: keep=%h want contiguous from lane 0", b, b_keep[b]);
      end
      for (int l = 0; l < PACK; l++) begin
        if (b_keep[b][l]) recv.push_back(b_data[b][l*8 +: 8]);
        else if (b_data[b][l*8 +: 8] !== 8'h00) zero_bad++;
      end
    end
    tests_run++;
    if (zero_bad != 0) begin
      tests_failed++;
      $display("FAIL rand_unused_lanes: %0d nonzero unused lanes, want 0", zero_bad);
    end
    mism = 0;
    for (int i = 0; i < recv.size() && i < sent.size(); i++)
      if (recv[i] !== sent[i]) mism++;
    tests_run++;
    if (recv.size() != sent.size() || popped.size() != sent.size() || mism != 0) begin
      tests_failed++;
      $display("FAIL rand_order: recv=%0d popped=%0d sent=%0d mismatches=%0d want equal counts and 0",
               recv.size(), popped.size(), sent.size(), mism);
    end
  endtask

  initial begin
    rrst_n    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    stall     = 1'b1;
    refresh();
    test_reset();
    test_full_beat();
    test_timeout();
    test_flush_pop();
    test_backpressure();
    test_reset_mid_fill();
    test_flush_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
